// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: predicts direction/target in IF,
// trains on the resolved outcome in ID and redirects fetch on a misprediction.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_LO  = IDX_BITS + 2;
    localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                if_hit;
    logic                upd_hit;
    logic [31:0]         actual_next;
    logic [31:0]         pred_next;

    // PC bits outside the index/tag fields carry no information for the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], if_pc[31:TAG_HI+1], upd_pc[1:0], upd_pc[31:TAG_HI+1]};

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    assign if_idx  = if_pc[TAG_LO-1:2];
    assign if_tag  = if_pc[TAG_HI:TAG_LO];
    assign upd_idx = upd_pc[TAG_LO-1:2];
    assign upd_tag = upd_pc[TAG_HI:TAG_LO];

    // Fetch-side lookup: reads pre-edge table contents, no write bypass.
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
    end

    // Resolve: compare next-PCs so a right direction with a stale target still flushes.
    always_comb begin
        upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        actual_next = upd_taken ? upd_target : upd_pc + 32'd4;
        pred_next   = upd_pred_taken ? upd_pred_target : upd_pc + 32'd4;
        mispredict  = 1'b0;
        redirect_pc = 32'd0;
        if (upd_valid && !rst) begin
            mispredict  = (actual_next != pred_next);
            redirect_pc = actual_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
            branch_cnt <= 32'd0;
            miss_cnt   <= 32'd0;
        end else if (upd_valid) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (mispredict) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_q[upd_idx]    <= ctr_inc(ctr_q[upd_idx]);
                    target_q[upd_idx] <= upd_target;
                end else begin
                    ctr_q[upd_idx] <= ctr_dec(ctr_q[upd_idx]);
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever occupied this index.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, saturation, aliasing,
// same-cycle read/write ordering and reset during an update.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.IDX_BITS(6), .TAG_BITS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .miss_cnt       (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        #1;
    endtask

    task automatic idle();
        upd_valid       = 1'b0;
        upd_pc          = 32'd0;
        upd_taken       = 1'b0;
        upd_target      = 32'd0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'd0;
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        if_pc = 32'd0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Empty table after reset
        if_pc = 32'h40;
        #1;
        check("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("reset_pred_target", pred_target, 32'h44);
        check("reset_branch_cnt", branch_cnt, 32'd0);
        check("reset_miss_cnt", miss_cnt, 32'd0);

        // First taken resolution allocates; same-cycle read still sees old contents
        resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
        check("alloc_redirect", redirect_pc, 32'h100);
        check("same_cycle_pred", {31'd0, pred_taken}, 32'd0);
        tick();
        idle();
        check("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
        check("alloc_pred_target", pred_target, 32'h100);
        check("alloc_miss_cnt", miss_cnt, 32'd1);
        check("alloc_branch_cnt", branch_cnt, 32'd1);
        check("idle_mispredict", {31'd0, mispredict}, 32'd0);
        check("idle_redirect", redirect_pc, 32'd0);

        // Four more correctly predicted taken resolutions: ctr saturates at 11
        for (int i = 0; i < 4; i++) begin
            resolve(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
            check("sat_taken_mispredict", {31'd0, mispredict}, 32'd0);
            tick();
        end
        idle();
        check("sat_branch_cnt", branch_cnt, 32'd5);
        check("sat_miss_cnt", miss_cnt, 32'd1);

        // First not-taken: 11 -> 10, still predicts taken
        resolve(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        check("nt1_mispredict", {31'd0, mispredict}, 32'd1);
        check("nt1_redirect", redirect_pc, 32'h44);
        tick();
        idle();
        check("nt1_pred_taken", {31'd0, pred_taken}, 32'd1);
        check("nt1_miss_cnt", miss_cnt, 32'd2);

        // Second not-taken: 10 -> 01, now predicts not taken
        resolve(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        check("nt2_mispredict", {31'd0, mispredict}, 32'd1);
        check("nt2_redirect", redirect_pc, 32'h44);
        tick();
        idle();
        check("nt2_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("nt2_pred_target", pred_target, 32'h44);
        check("nt2_branch_cnt", branch_cnt, 32'd7);
        check("nt2_miss_cnt", miss_cnt, 32'd3);

        // Hit and taken with a new target: 01 -> 10, target refreshed
        resolve(32'h40, 1'b1, 32'h180, 1'b0, 32'h44);
        check("retarget_mispredict", {31'd0, mispredict}, 32'd1);
        tick();
        idle();
        check("retarget_pred_taken", {31'd0, pred_taken}, 32'd1);
        check("retarget_pred_target", pred_target, 32'h180);

        // Same index, different tag: entry replaced
        resolve(32'h4040, 1'b1, 32'h200, 1'b0, 32'h4044);
        check("alias_mispredict", {31'd0, mispredict}, 32'd1);
        check("alias_redirect", redirect_pc, 32'h200);
        tick();
        idle();
        check("alias_old_pred", {31'd0, pred_taken}, 32'd0);
        check("alias_old_target", pred_target, 32'h44);
        if_pc = 32'h4040;
        #1;
        check("alias_new_pred", {31'd0, pred_taken}, 32'd1);
        check("alias_new_target", pred_target, 32'h200);
        check("alias_branch_cnt", branch_cnt, 32'd9);
        check("alias_miss_cnt", miss_cnt, 32'd5);

        // Miss and not taken: no allocation, no mispredict
        resolve(32'h80, 1'b0, 32'h300, 1'b0, 32'h84);
        check("miss_nt_mispredict", {31'd0, mispredict}, 32'd0);
        check("miss_nt_redirect", redirect_pc, 32'h84);
        tick();
        idle();
        if_pc = 32'h80;
        #1;
        check("miss_nt_pred", {31'd0, pred_taken}, 32'd0);
        check("miss_nt_branch_cnt", branch_cnt, 32'd10);
        check("miss_nt_miss_cnt", miss_cnt, 32'd5);

        // Right direction, stale target: target comparison flags it
        resolve(32'h4040, 1'b1, 32'h300, 1'b1, 32'h200);
        check("stale_tgt_mispredict", {31'd0, mispredict}, 32'd1);
        check("stale_tgt_redirect", redirect_pc, 32'h300);
        tick();
        idle();
        if_pc = 32'h4040;
        #1;
        check("stale_tgt_target", pred_target, 32'h300);
        check("stale_tgt_miss_cnt", miss_cnt, 32'd6);

        // Reset wins over a pending update
        rst = 1'b1;
        resolve(32'h4040, 1'b1, 32'h500, 1'b0, 32'h4044);
        check("rst_upd_mispredict", {31'd0, mispredict}, 32'd0);
        check("rst_upd_redirect", redirect_pc, 32'd0);
        tick();
        rst = 1'b0;
        idle();
        check("rst_upd_branch_cnt", branch_cnt, 32'd0);
        check("rst_upd_miss_cnt", miss_cnt, 32'd0);
        check("rst_upd_pred", {31'd0, pred_taken}, 32'd0);
        check("rst_upd_target", pred_target, 32'h4044);
        if_pc = 32'h40;
        #1;
        check("rst_upd_pred_40", {31'd0, pred_taken}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
